// File: rtl/di_stream_fifo.sv
// DI-bus read-side stream FIFO: fabric pushes words, host pops via data reg.
// Status reg reports fill level plus sticky overflow/underflow flags.
module di_stream_fifo #(
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [15:0] EP_ADDR    = 16'h0,
  parameter logic [15:0] DATA_REG   = 16'h0,
  parameter logic [15:0] STATUS_REG = 16'h1
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  diReset,
  input  logic [15:0]           diEpAddr,
  input  logic [15:0]           diRegAddr,
  input  logic                  diRead,
  output logic [15:0]           diRegDataOut,
  output logic                  rdwr_ready,
  input  logic                  wr_en,
  input  logic [15:0]           wr_data,
  output logic                  wr_full,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic                  ovf;
  logic                  unf;

  logic                  sel_d;
  logic                  sel_s;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  rd_try;
  logic                  st_clr;
  logic [DEPTH_LOG2:0]   count_n;
  logic [15:0]           st_word;

  assign sel_d   = (diEpAddr == EP_ADDR) && (diRegAddr == DATA_REG);
  assign sel_s   = (diEpAddr == EP_ADDR) && (diRegAddr == STATUS_REG);
  assign empty   = (count == '0);
  assign wr_full = (count == FULL_CNT);

  assign rd_try  = diRead && sel_d;
  assign pop     = rd_try && rdwr_ready && !empty;
  // Full blocks a push even when a pop frees a slot this same cycle.
  assign push    = wr_en && !wr_full;
  assign st_clr  = diRead && sel_s;

  assign count_n = count
                 + (DEPTH_LOG2 + 1)'(push)
                 - (DEPTH_LOG2 + 1)'(pop);

  always_comb begin
    st_word                 = '0;
    st_word[15]             = ovf;
    st_word[14]             = unf;
    st_word[DEPTH_LOG2:0]   = count;
  end

  always_comb begin
    diRegDataOut = '0;
    if (sel_d) begin
      diRegDataOut = empty ? '0 : mem[rd_ptr];
    end else if (sel_s) begin
      diRegDataOut = st_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb || diReset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      unf        <= 1'b0;
      rdwr_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      count      <= count_n;
      // A fresh error in the clearing cycle keeps its flag set.
      ovf        <= (ovf && !st_clr) || (wr_en && wr_full);
      unf        <= (unf && !st_clr) || (rd_try && !pop);
      rdwr_ready <= sel_d ? (count_n != '0) : 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && resetb && !diReset) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_di_stream_fifo.sv
// Directed bench for di_stream_fifo: ordering, full/overflow, underflow,
// simultaneous push/pop, flush and pointer wrap.
module tb_di_stream_fifo;

  logic        clk = 1'b0;
  logic        resetb;
  logic        diReset;
  logic [15:0] diEpAddr;
  logic [15:0] diRegAddr;
  logic        diRead;
  logic [15:0] diRegDataOut;
  logic        rdwr_ready;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        wr_full;
  logic [4:0]  count;

  int checks = 0;
  int failures = 0;

  di_stream_fifo #(
    .DEPTH_LOG2 (4),
    .EP_ADDR    (16'h0),
    .DATA_REG   (16'h0),
    .STATUS_REG (16'h1)
  ) dut (
    .clk          (clk),
    .resetb       (resetb),
    .diReset      (diReset),
    .diEpAddr     (diEpAddr),
    .diRegAddr    (diRegAddr),
    .diRead       (diRead),
    .diRegDataOut (diRegDataOut),
    .rdwr_ready   (rdwr_ready),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .wr_full      (wr_full),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetb    = 1'b0;
    tick();
    tick();
    diRegAddr = 16'h0;
    resetb    = 1'b1;
    tick();
    checks++;
    if (count !== 5'd0) begin
      failures++;
      $display("FAIL reset_count got=%0d exp=0", count);
    end
    checks++;
    if (rdwr_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=0", rdwr_ready);
    end
    checks++;
    if (diRegDataOut !== 16'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0000", diRegDataOut);
    end
    checks++;
    if (wr_full !== 1'b0) begin
      failures++;
      $display("FAIL reset_full got=%b exp=0", wr_full);
    end
  endtask

  task automatic test_order();
    logic [15:0] exp_w [3];
    exp_w[0]  = 16'hA001;
    exp_w[1]  = 16'hA002;
    exp_w[2]  = 16'hA003;
    diRegAddr = 16'h0;
    for (int i = 0; i < 3; i++) begin
      wr_en   = 1'b1;
      wr_data = exp_w[i];
      tick();
    end
    wr_en = 1'b0;
    checks++;
    if (count !== 5'd3) begin
      failures++;
      $display("FAIL order_count3 got=%0d exp=3", count);
    end
    checks++;
    if (rdwr_ready !== 1'b1) begin
      failures++;
      $display("FAIL order_ready got=%b exp=1", rdwr_ready);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (diRegDataOut !== exp_w[i]) begin
        failures++;
        $display("FAIL order_data%0d got=%h exp=%h", i, diRegDataOut, exp_w[i]);
      end
      diRead = 1'b1;
      tick();
    end
    diRead = 1'b0;
    checks++;
    if (count !== 5'd0) begin
      failures++;
      $display("FAIL order_count0 got=%0d exp=0", count);
    end
    checks++;
    if (rdwr_ready !== 1'b0) begin
      failures++;
      $display("FAIL order_ready_drop got=%b exp=0", rdwr_ready);
    end
  endtask

  task automatic test_full();
    logic [15:0] exp_d;
    diRegAddr = 16'h5;
    for (int i = 0; i < 16; i++) begin
      wr_en   = 1'b1;
      wr_data = 16'hC000 + 16'(i);
      tick();
    end
    wr_data = 16'hBEEF;
    tick();
    wr_en = 1'b0;
    checks++;
    if (wr_full !== 1'b1) begin
      failures++;
      $display("FAIL full_flag got=%b exp=1", wr_full);
    end
    checks++;
    if (count !== 5'd16) begin
      failures++;
      $display("FAIL full_count got=%0d exp=16", count);
    end
    diRegAddr = 16'h1;
    #1;
    checks++;
    if (diRegDataOut !== 16'h8010) begin
      failures++;
      $display("FAIL status_ovf got=%h exp=8010", diRegDataOut);
    end
    diRead = 1'b1;
    tick();
    diRead = 1'b0;
    checks++;
    if (diRegDataOut !== 16'h0010) begin
      failures++;
      $display("FAIL status_clear got=%h exp=0010", diRegDataOut);
    end
    diRead  = 1'b1;
    wr_en   = 1'b1;
    wr_data = 16'hDEAD;
    tick();
    diRead = 1'b0;
    wr_en  = 1'b0;
    checks++;
    if (diRegDataOut !== 16'h8010) begin
      failures++;
      $display("FAIL status_race got=%h exp=8010", diRegDataOut);
    end
    diRead = 1'b1;
    tick();
    diRead = 1'b0;
    diRegAddr = 16'h0;
    #1;
    for (int i = 0; i < 16; i++) begin
      exp_d = 16'hC000 + 16'(i);
      checks++;
      if (diRegDataOut !== exp_d) begin
        failures++;
        $display("FAIL drain%0d got=%h exp=%h", i, diRegDataOut, exp_d);
      end
      diRead = 1'b1;
      tick();
    end
    diRead = 1'b0;
    checks++;
    if (count !== 5'd0 || rdwr_ready !== 1'b0) begin
      failures++;
      $display("FAIL drain_end got=%0d/%b exp=0/0", count, rdwr_ready);
    end
  endtask

  task automatic test_underflow();
    diRegAddr = 16'h0;
    diRead    = 1'b1;
    tick();
    diRead = 1'b0;
    checks++;
    if (count !== 5'd0 || diRegDataOut !== 16'h0) begin
      failures++;
      $display("FAIL unf_empty got=%0d/%h exp=0/0000", count, diRegDataOut);
    end
    diRegAddr = 16'h1;
    #1;
    checks++;
    if (diRegDataOut !== 16'h4000) begin
      failures++;
      $display("FAIL status_unf got=%h exp=4000", diRegDataOut);
    end
    diRead = 1'b1;
    tick();
    diRead    = 1'b0;
    diRegAddr = 16'h0;
    wr_en     = 1'b1;
    wr_data   = 16'h1234;
    tick();
    wr_en = 1'b0;
    checks++;
    if (diRegDataOut !== 16'h1234) begin
      failures++;
      $display("FAIL unf_ptr got=%h exp=1234", diRegDataOut);
    end
  endtask

  task automatic test_simul();
    checks++;
    if (count !== 5'd1 || rdwr_ready !== 1'b1) begin
      failures++;
      $display("FAIL simul_pre got=%0d/%b exp=1/1", count, rdwr_ready);
    end
    wr_en   = 1'b1;
    wr_data = 16'h5678;
    diRead  = 1'b1;
    tick();
    wr_en  = 1'b0;
    diRead = 1'b0;
    checks++;
    if (count !== 5'd1) begin
      failures++;
      $display("FAIL simul_count got=%0d exp=1", count);
    end
    checks++;
    if (diRegDataOut !== 16'h5678) begin
      failures++;
      $display("FAIL simul_head got=%h exp=5678", diRegDataOut);
    end
    diRead = 1'b1;
    tick();
    diRead = 1'b0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      wr_en   = 1'b1;
      wr_data = 16'hE000 + 16'(i);
      tick();
    end
    checks++;
    if (count !== 5'd5) begin
      failures++;
      $display("FAIL flush_pre got=%0d exp=5", count);
    end
    diReset = 1'b1;
    wr_data = 16'hE0FF;
    tick();
    diReset = 1'b0;
    wr_en   = 1'b0;
    checks++;
    if (count !== 5'd0 || rdwr_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush got=%0d/%b exp=0/0", count, rdwr_ready);
    end
    checks++;
    if (diRegDataOut !== 16'h0) begin
      failures++;
      $display("FAIL flush_data got=%h exp=0000", diRegDataOut);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] w;
    int bad;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      w       = 16'hD000 + 16'(i);
      wr_en   = 1'b1;
      wr_data = w;
      tick();
      wr_en = 1'b0;
      checks++;
      if (diRegDataOut !== w) begin
        failures++;
        bad++;
        if (bad < 5) $display("FAIL wrap%0d got=%h exp=%h", i, diRegDataOut, w);
      end
      diRead = 1'b1;
      tick();
      diRead = 1'b0;
    end
    checks++;
    if (count !== 5'd0) begin
      failures++;
      $display("FAIL wrap_end got=%0d exp=0", count);
    end
  endtask

  initial begin
    resetb    = 1'b0;
    diReset   = 1'b0;
    diEpAddr  = 16'h0;
    diRegAddr = 16'h0;
    diRead    = 1'b0;
    wr_en     = 1'b0;
    wr_data   = 16'h0;
    test_reset();
    test_order();
    test_full();
    test_underflow();
    test_simul();
    test_flush();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
